// File: rtl/delay_feedback_mixer.sv
// Echo-loop mixer for the delay buffer. Each dry sample is combined with the
// latest delayed sample to produce a feedback sample (back into the buffer) and
// a wet output sample. One multiplier is shared across a fixed 4-cycle sequence.
module delay_feedback_mixer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned COEF_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dry_valid,
    input  logic [DATA_WIDTH-1:0] dry_sample,
    output logic                  dry_ready,
    input  logic                  delayed_valid,
    input  logic [DATA_WIDTH-1:0] delayed_sample,
    input  logic [COEF_WIDTH-1:0] fb_gain,
    input  logic [COEF_WIDTH-1:0] mix_gain,
    output logic                  fb_valid,
    output logic [DATA_WIDTH-1:0] fb_sample,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_sample,
    output logic                  overrun
);

    localparam int unsigned ProdWidth = DATA_WIDTH + COEF_WIDTH;
    // One guard bit over the product keeps the add from ever wrapping.
    localparam int unsigned SumWidth  = ProdWidth + 1;

    localparam logic signed [SumWidth-1:0] SatMax =
        {{(SumWidth - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SumWidth-1:0] SatMin =
        {{(SumWidth - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StMulFb,
        StMulMix,
        StSum
    } state_e;

    state_e state_q, state_d;

    logic signed [DATA_WIDTH-1:0] dry_q, dry_d;
    logic signed [DATA_WIDTH-1:0] op_q, op_d;
    logic signed [COEF_WIDTH-1:0] fb_gain_q, fb_gain_d;
    logic signed [COEF_WIDTH-1:0] mix_gain_q, mix_gain_d;
    logic signed [ProdWidth-1:0]  p_fb_q, p_fb_d;
    logic signed [ProdWidth-1:0]  p_mix_q, p_mix_d;
    logic signed [DATA_WIDTH-1:0] lat_q, lat_d;
    logic                         seen_q, seen_d;
    logic [DATA_WIDTH-1:0]        fb_sample_q, fb_sample_d;
    logic [DATA_WIDTH-1:0]        out_sample_q, out_sample_d;
    logic                         fb_valid_q, fb_valid_d;
    logic                         out_valid_q, out_valid_d;
    logic                         overrun_q, overrun_d;

    logic signed [COEF_WIDTH-1:0] mul_b;
    logic signed [ProdWidth-1:0]  mul_p;

    // Scale a product back to sample units (floor), add the dry sample, saturate.
    function automatic logic [DATA_WIDTH-1:0] mix_path(
        input logic signed [ProdWidth-1:0]  prod,
        input logic signed [DATA_WIDTH-1:0] dry
    );
        logic signed [ProdWidth-1:0] prod_sh;
        logic signed [SumWidth-1:0]  sum;
        prod_sh = prod >>> (COEF_WIDTH - 1);
        sum = {prod_sh[ProdWidth-1], prod_sh}
            + {{(SumWidth - DATA_WIDTH){dry[DATA_WIDTH-1]}}, dry};
        if (sum > SatMax) begin
            mix_path = SatMax[DATA_WIDTH-1:0];
        end else if (sum < SatMin) begin
            mix_path = SatMin[DATA_WIDTH-1:0];
        end else begin
            mix_path = sum[DATA_WIDTH-1:0];
        end
    endfunction

    // Shared multiplier: feedback gain in StMulFb, mix gain otherwise.
    always_comb begin
        mul_b = (state_q == StMulFb) ? fb_gain_q : mix_gain_q;
        mul_p = op_q * mul_b;
    end

    // Next-state logic for the sequencer, operand capture and result registers.
    always_comb begin
        state_d      = state_q;
        dry_d        = dry_q;
        op_d         = op_q;
        fb_gain_d    = fb_gain_q;
        mix_gain_d   = mix_gain_q;
        p_fb_d       = p_fb_q;
        p_mix_d      = p_mix_q;
        lat_d        = lat_q;
        seen_d       = seen_q;
        fb_sample_d  = fb_sample_q;
        out_sample_d = out_sample_q;
        fb_valid_d   = 1'b0;
        out_valid_d  = 1'b0;
        overrun_d    = overrun_q;

        if (delayed_valid) begin
            lat_d  = delayed_sample;
            seen_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (dry_valid) begin
                    dry_d      = dry_sample;
                    fb_gain_d  = fb_gain;
                    mix_gain_d = mix_gain;
                    // A delayed sample arriving on the same edge takes priority;
                    // before the buffer is primed the operand is zero.
                    if (delayed_valid) begin
                        op_d = delayed_sample;
                    end else if (seen_q) begin
                        op_d = lat_q;
                    end else begin
                        op_d = '0;
                    end
                    state_d = StMulFb;
                end
            end
            StMulFb: begin
                p_fb_d  = mul_p;
                state_d = StMulMix;
            end
            StMulMix: begin
                p_mix_d = mul_p;
                state_d = StSum;
            end
            StSum: begin
                fb_sample_d  = mix_path(p_fb_q, dry_q);
                out_sample_d = mix_path(p_mix_q, dry_q);
                fb_valid_d   = 1'b1;
                out_valid_d  = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Busy: the sample is dropped and the condition is remembered until reset.
        if (dry_valid && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            dry_q        <= '0;
            op_q         <= '0;
            fb_gain_q    <= '0;
            mix_gain_q   <= '0;
            p_fb_q       <= '0;
            p_mix_q      <= '0;
            lat_q        <= '0;
            seen_q       <= 1'b0;
            fb_sample_q  <= '0;
            out_sample_q <= '0;
            fb_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dry_q        <= dry_d;
            op_q         <= op_d;
            fb_gain_q    <= fb_gain_d;
            mix_gain_q   <= mix_gain_d;
            p_fb_q       <= p_fb_d;
            p_mix_q      <= p_mix_d;
            lat_q        <= lat_d;
            seen_q       <= seen_d;
            fb_sample_q  <= fb_sample_d;
            out_sample_q <= out_sample_d;
            fb_valid_q   <= fb_valid_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dry_ready  = (state_q == StIdle);
    assign fb_sample  = fb_sample_q;
    assign out_sample = out_sample_q;
    assign fb_valid   = fb_valid_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;

endmodule
